// File: rtl/coeff_center_pipe_pkg.sv
// Shared constants, mode encodings and per-security-level parameters
// for the coefficient center/uncenter pipeline.
package coeff_center_pipe_pkg;

  localparam logic [31:0] Q       = 32'd8380417;
  localparam logic [31:0] T_CONST = 32'd4096;

  typedef enum logic [2:0] {
    M_NONE   = 3'd0,
    M_ETA    = 3'd1,
    M_T0     = 3'd2,
    M_T1     = 3'd3,
    M_GAMMA1 = 3'd4
  } mode_e;

  localparam logic DIR_UNCENTER = 1'b0;
  localparam logic DIR_CENTER   = 1'b1;

  // Reserved encodings 5..7 fold onto NONE.
  function automatic mode_e norm_mode(input logic [2:0] m);
    case (m)
      3'd1:    return M_ETA;
      3'd2:    return M_T0;
      3'd3:    return M_T1;
      3'd4:    return M_GAMMA1;
      default: return M_NONE;
    endcase
  endfunction

  function automatic logic [31:0] eta_of(input logic [2:0] sec_lvl);
    return (sec_lvl == 3'd3) ? 32'd4 : 32'd2;
  endfunction

  function automatic logic [31:0] gamma1_of(input logic [2:0] sec_lvl);
    return (sec_lvl == 3'd2) ? 32'd131072 : 32'd524288;
  endfunction

  // Centering constant K for the symmetric modes; zero where unused.
  function automatic logic [31:0] k_of(input mode_e m, input logic [2:0] sec_lvl);
    case (m)
      M_ETA:    return eta_of(sec_lvl);
      M_T0:     return T_CONST;
      M_GAMMA1: return gamma1_of(sec_lvl);
      default:  return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/coeff_center_lane.sv
// One lane of the converter: stage 1 registers the operand, t1 and the
// comparisons; stage 2 registers the selected subtraction result and error.
module coeff_center_lane
  import coeff_center_pipe_pkg::*;
#(
  parameter int W = 23,
  parameter int D = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s1_load_i,
  input  logic         s2_load_i,
  input  logic [W-1:0] v_i,
  input  mode_e        mode_i,
  input  logic         dir_i,
  input  logic [2:0]   sec_lvl_i,
  input  mode_e        mode_s1_i,
  input  logic         dir_s1_i,
  input  logic [2:0]   sec_lvl_s1_i,
  output logic [W-1:0] res_o,
  output logic         err_o
);

  localparam int TW = W - D + 1;

  logic [31:0]   v_ext, k_in;
  logic [TW-1:0] t1_d;
  logic          gt_d, err_d;

  logic [W-1:0]  v_q;
  logic [TW-1:0] t1_q;
  logic          gt_q, err1_q;

  logic [31:0]   v1_ext, t1_ext, k_s1;
  logic [W-1:0]  sym_d, res_d;

  logic [W-1:0]  res_q;
  logic          err_q;

  always_comb begin
    v_ext = 32'(v_i);
    k_in  = k_of(mode_i, sec_lvl_i);
    t1_d  = TW'((v_ext + T_CONST - 32'd1) >> D);
    gt_d  = v_ext > k_in;
    err_d = 1'b0;
    if (dir_i == DIR_UNCENTER) begin
      err_d = v_ext >= Q;
    end else begin
      case (mode_i)
        M_ETA:    err_d = v_ext > (eta_of(sec_lvl_i) << 1);
        M_T0:     err_d = v_ext >= (32'd1 << D);
        M_T1:     err_d = v_ext >= (32'd1 << (W - D));
        M_GAMMA1: err_d = v_ext >= (gamma1_of(sec_lvl_i) << 1);
        default:  err_d = v_ext >= Q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q    <= '0;
      t1_q   <= '0;
      gt_q   <= 1'b0;
      err1_q <= 1'b0;
    end else if (s1_load_i) begin
      v_q    <= v_i;
      t1_q   <= t1_d;
      gt_q   <= gt_d;
      err1_q <= err_d;
    end
  end

  // ETA/GAMMA1 in both directions and T0 centering share the K-relative form.
  always_comb begin
    v1_ext = 32'(v_q);
    t1_ext = 32'(t1_q);
    k_s1   = k_of(mode_s1_i, sec_lvl_s1_i);
    sym_d  = gt_q ? W'(k_s1 + Q - v1_ext) : W'(k_s1 - v1_ext);
    res_d  = v_q;
    case (mode_s1_i)
      M_ETA, M_GAMMA1: res_d = sym_d;
      M_T0:   res_d = (dir_s1_i == DIR_UNCENTER) ? W'(T_CONST - v1_ext + (t1_ext << D)) : sym_d;
      M_T1:   res_d = (dir_s1_i == DIR_UNCENTER) ? W'(t1_ext) : W'(v1_ext << D);
      default: res_d = v_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      res_q <= '0;
      err_q <= 1'b0;
    end else if (s2_load_i) begin
      res_q <= res_d;
      err_q <= err1_q;
    end
  end

  assign res_o = res_q;
  assign err_o = err_q;

endmodule

// File: rtl/coeff_center_pipe.sv
// Multi-lane, two-stage coefficient center/uncenter pipeline with
// valid/ready backpressure and a sticky range-error flag.
module coeff_center_pipe
  import coeff_center_pipe_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W     = 23,
  parameter int D     = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_data,
  input  logic [2:0]         in_mode,
  input  logic               in_dir,
  input  logic [2:0]         in_sec_lvl,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data,
  output logic               out_last,
  output logic [LANES-1:0]   out_err,
  output logic               err_sticky,
  input  logic               err_clr
);

  logic       s1_valid_q, s2_valid_q;
  mode_e      mode_s1_q;
  logic       dir_s1_q;
  logic [2:0] sec_s1_q;
  logic       last_s1_q, last_s2_q;
  logic       err_sticky_q;

  mode_e      in_mode_n;
  logic       s2_adv, s1_load, s2_load;

  assign in_mode_n = norm_mode(in_mode);

  // S2 may take a new beat when empty or when its current beat leaves.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !(s1_valid_q && s2_valid_q && !out_ready);
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s2_adv && s1_valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      mode_s1_q    <= M_NONE;
      dir_s1_q     <= DIR_UNCENTER;
      sec_s1_q     <= 3'd0;
      last_s1_q    <= 1'b0;
      last_s2_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (s1_load) begin
        mode_s1_q <= in_mode_n;
        dir_s1_q  <= in_dir;
        sec_s1_q  <= in_sec_lvl;
        last_s1_q <= in_last;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
      end
      if (s2_load) begin
        last_s2_q <= last_s1_q;
      end
      if (err_clr) begin
        err_sticky_q <= 1'b0;
      end else if (s2_valid_q && out_ready && |out_err) begin
        err_sticky_q <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      coeff_center_lane #(
        .W (W),
        .D (D)
      ) u_lane (
        .clk          (clk),
        .rst          (rst),
        .s1_load_i    (s1_load),
        .s2_load_i    (s2_load),
        .v_i          (in_data[gi*W +: W]),
        .mode_i       (in_mode_n),
        .dir_i        (in_dir),
        .sec_lvl_i    (in_sec_lvl),
        .mode_s1_i    (mode_s1_q),
        .dir_s1_i     (dir_s1_q),
        .sec_lvl_s1_i (sec_s1_q),
        .res_o        (out_data[gi*W +: W]),
        .err_o        (out_err[gi])
      );
    end
  endgenerate

  assign out_valid  = s2_valid_q;
  assign out_last   = last_s2_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_coeff_center_pipe.sv
// Directed and randomized bench for coeff_center_pipe against an
// arithmetic reference model with an in-order scoreboard.
module tb_coeff_center_pipe;

  localparam int LANES = 4;
  localparam int W     = 23;
  localparam int D     = 13;
  localparam int QI    = 8380417;
  localparam longint TT = 4096;

  typedef struct {
    logic [LANES*W-1:0] data;
    logic [LANES-1:0]   err;
    logic               last;
  } item_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [LANES*W-1:0] in_data = '0;
  logic [2:0]         in_mode = 3'd0;
  logic               in_dir = 1'b0;
  logic [2:0]         in_sec_lvl = 3'd2;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [LANES*W-1:0] out_data;
  logic               out_last;
  logic [LANES-1:0]   out_err;
  logic               err_sticky;
  logic               err_clr = 1'b0;

  int    checks = 0;
  int    errors = 0;
  int    n_out = 0;
  logic  sticky_model = 1'b0;
  logic  accepted = 1'b0;
  logic  saw_stall = 1'b0;
  item_t sb[$];

  logic [31:0] edges [10] = '{32'd8191, 32'd8192, 32'd1023, 32'd1024, 32'd262143,
                              32'd262144, 32'd1048575, 32'd1048576, 32'd131072, 32'd524288};
  logic [2:0]  sec_tab [3] = '{3'd2, 3'd3, 3'd5};

  coeff_center_pipe #(.LANES(LANES), .W(W), .D(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .in_dir     (in_dir),
    .in_sec_lvl (in_sec_lvl),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: each lane converted straight from the arithmetic rules.
  function automatic item_t model_beat(input logic [LANES*W-1:0] d, input logic [2:0] mode,
                                       input logic dir, input logic [2:0] sec, input logic last);
    item_t it;
    longint v, r, eta, g, k, t1, t0;
    int m;
    logic e;
    logic [63:0] rb;
    eta = (sec == 3'd3) ? 4 : 2;
    g   = (sec == 3'd2) ? 131072 : 524288;
    m   = (mode > 3'd4) ? 0 : int'(mode);
    it.data = '0;
    it.err  = '0;
    it.last = last;
    for (int l = 0; l < LANES; l++) begin
      v = 0;
      v[W-1:0] = d[l*W +: W];
      r = v;
      if (dir == 1'b0) begin
        e = (v >= QI);
        case (m)
          1: r = (v > eta) ? eta + QI - v : eta - v;
          2: begin
            t1 = (v + TT - 1) >> D;
            t0 = v - (t1 << D);
            r  = TT - t0;
          end
          3: r = (v + TT - 1) >> D;
          4: r = (v > g) ? g + QI - v : g - v;
          default: r = v;
        endcase
      end else begin
        k = (m == 1) ? eta : (m == 2) ? TT : g;
        case (m)
          1, 2, 4: r = (v <= k) ? k - v : QI + k - v;
          3: r = v << D;
          default: r = v;
        endcase
        case (m)
          1: e = (v > 2 * eta);
          2: e = (v >= 8192);
          3: e = (v >= 1024);
          4: e = (v >= 2 * g);
          default: e = (v >= QI);
        endcase
      end
      rb = r;
      it.data[l*W +: W] = rb[W-1:0];
      it.err[l] = e;
    end
    return it;
  endfunction

  function automatic logic [W-1:0] rand_val();
    logic [31:0] x;
    case ($urandom_range(0, 4))
      0: x = $urandom_range(0, 20);
      1: x = $urandom_range(0, QI - 1);
      2: x = $urandom_range(QI - 3, QI + 3);
      3: x = $urandom;
      default: x = edges[$urandom_range(0, 9)];
    endcase
    return W'(x);
  endfunction

  function automatic logic [LANES*W-1:0] rand_data();
    logic [LANES*W-1:0] d;
    for (int l = 0; l < LANES; l++) d[l*W +: W] = rand_val();
    return d;
  endfunction

  // One clock: scoreboard bookkeeping at negedge, sticky check after posedge.
  task automatic cycle();
    item_t it;
    logic  xfer_err;
    logic  exp_ready;
    xfer_err = 1'b0;
    accepted = 1'b0;
    @(negedge clk);
    exp_ready = !(sb.size() == 2 && !out_ready);
    check("in_ready", 128'(in_ready), 128'(exp_ready));
    if (out_valid && !out_ready && sb.size() != 0) begin
      check("hold_data", 128'(out_data), 128'(sb[0].data));
      check("hold_last", 128'(out_last), 128'(sb[0].last));
    end
    if (out_valid && out_ready) begin
      check("spurious_beat", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        it = sb.pop_front();
        check("out_data", 128'(out_data), 128'(it.data));
        check("out_err", 128'(out_err), 128'(it.err));
        check("out_last", 128'(out_last), 128'(it.last));
        xfer_err = |it.err;
        n_out++;
        $display("beat %0d data=%h err=%b last=%b", n_out, out_data, out_err, out_last);
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(model_beat(in_data, in_mode, in_dir, in_sec_lvl, in_last));
      accepted = 1'b1;
    end
    if (!in_ready) saw_stall = 1'b1;
    if (err_clr) sticky_model = 1'b0;
    else if (xfer_err) sticky_model = 1'b1;
    @(posedge clk);
    #1;
    check("err_sticky", 128'(err_sticky), 128'(sticky_model));
  endtask

  // Single beat with constant expectations and a two-cycle latency check.
  task automatic send_check(input string tag, input logic [LANES*W-1:0] d, input logic [2:0] mode,
                            input logic dir, input logic [2:0] sec,
                            input logic [LANES*W-1:0] exp_d, input logic [LANES-1:0] exp_e);
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_data    = d;
    in_mode    = mode;
    in_dir     = dir;
    in_sec_lvl = sec;
    in_last    = 1'b0;
    cycle();
    in_valid = 1'b0;
    check({tag, "_lat1"}, 128'(out_valid), 128'(0));
    cycle();
    check({tag, "_lat2"}, 128'(out_valid), 128'(1));
    check({tag, "_data"}, 128'(out_data), 128'(exp_d));
    check({tag, "_err"}, 128'(out_err), 128'(exp_e));
    cycle();
  endtask

  initial begin
    int sent;
    int n0;
    int acc;
    logic [LANES*W-1:0] d;

    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    check("rst_out_err", 128'(out_err), 128'(0));
    check("rst_out_last", 128'(out_last), 128'(0));
    check("rst_sticky", 128'(err_sticky), 128'(0));
    rst = 1'b1;
    check("rst_in_ready", 128'(in_ready), 128'(1));

    // Uncenter ETA, sec_lvl 3
    send_check("eta_unc", {23'(QI - 4), 23'(QI - 1), 23'd4, 23'd0}, 3'd1, 1'b0, 3'd3,
               {23'd8, 23'd5, 23'd0, 23'd4}, 4'b0000);
    // Uncenter T1, T0; center T0
    send_check("t1_unc", {23'd8191, 23'd0, 23'(QI - 1), 23'd5000}, 3'd3, 1'b0, 3'd2,
               {23'd1, 23'd0, 23'd1023, 23'd1}, 4'b0000);
    send_check("t0_unc", {23'd4097, 23'd4096, 23'd0, 23'd5000}, 3'd2, 1'b0, 3'd5,
               {23'd8191, 23'd0, 23'd4096, 23'd7288}, 4'b0000);
    send_check("t0_cen", {23'd4096, 23'd8191, 23'd0, 23'd7288}, 3'd2, 1'b1, 3'd5,
               {23'd0, 23'd8376322, 23'd4096, 23'd8377225}, 4'b0000);
    // Center GAMMA1, sec_lvl 2, with one out-of-range lane
    send_check("g1_cen", {23'd131072, 23'd262144, 23'd131073, 23'd0}, 3'd4, 1'b1, 3'd2,
               {23'd0, 23'd8249345, 23'(QI - 1), 23'd131072}, 4'b0100);
    check("sticky_set", 128'(err_sticky), 128'(1));
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("sticky_clr", 128'(err_sticky), 128'(0));

    // Backpressure: 8 beats, out_ready low during cycles 3..6
    saw_stall = 1'b0;
    sent = 0;
    d = rand_data();
    for (int c = 0; c < 40; c++) begin
      if (sent == 8 && sb.size() == 0) break;
      out_ready  = !(c >= 3 && c <= 6);
      in_valid   = (sent < 8);
      in_data    = d;
      in_mode    = 3'(sent % 5);
      in_dir     = sent[0];
      in_sec_lvl = sec_tab[sent % 3];
      in_last    = (sent == 7);
      cycle();
      if (accepted) begin
        sent++;
        d = rand_data();
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    out_ready = 1'b1;
    check("bp_sent", 128'(sent), 128'(8));
    check("bp_drained", 128'(sb.size()), 128'(0));
    check("bp_ready_drop", 128'(saw_stall), 128'(1));

    // Mixed sideband back-to-back at full rate
    n0  = n_out;
    acc = 0;
    for (int i = 0; i < 18; i++) begin
      in_valid   = (i < 16);
      in_data    = rand_data();
      in_mode    = 3'(i % 5);
      in_dir     = i[0];
      in_sec_lvl = sec_tab[i % 3];
      cycle();
      if (accepted) acc++;
    end
    in_valid = 1'b0;
    check("mix_accepted", 128'(acc), 128'(16));
    check("mix_delivered", 128'(n_out - n0), 128'(16));

    // Reset with two beats in flight after an error beat set err_sticky
    in_valid = 1'b1;
    in_data  = {LANES{23'(QI + 5)}};
    in_mode  = 3'd0;
    in_dir   = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (2) cycle();
    check("pre_rst_sticky", 128'(err_sticky), 128'(1));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (2) begin
      in_data = rand_data();
      cycle();
    end
    in_valid = 1'b0;
    check("pre_rst_inflight", 128'(sb.size()), 128'(2));
    rst = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    sticky_model = 1'b0;
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_sticky", 128'(err_sticky), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(1));
    check("mid_rst_out_data", 128'(out_data), 128'(0));
    rst = 1'b1;
    out_ready = 1'b1;
    n0 = n_out;
    repeat (5) cycle();
    check("post_rst_no_stale", 128'(n_out - n0), 128'(0));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = rand_data();
      in_mode    = 3'($urandom_range(0, 7));
      in_dir     = 1'($urandom_range(0, 1));
      in_sec_lvl = 3'($urandom_range(0, 7));
      in_last    = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 3) != 0);
      err_clr    = ($urandom_range(0, 15) == 0);
      cycle();
    end
    in_valid  = 1'b0;
    err_clr   = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      cycle();
    end
    check("final_drain", 128'(sb.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coeff_center_pipe.md
Name: coeff_center_pipe

Overview:
- Parametrised, pipelined, multi-lane successor to the combinational coefficient uncenter logic.
- Converts LANES coefficients per beat in either direction:
  - uncenter: mod-q value to packed non-negative offset (for bit-packing).
  - center: packed offset back to mod-q value (for unpacking).
- Sits between the polynomial RAM read port and the pack/unpack shifters.
- Valid/ready handshake with backpressure, per-beat mode/direction sideband, range-error detection.

Parameters:
- LANES, 4, coefficients processed per beat.
- W, 23, coefficient width (Q = 8380417 must fit).
- D, 13, dropped bits for Power2Round (T = 2^(D-1)).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts beat when in_valid & in_ready.
- in_data  in  LANES*W  coefficients, lane 0 in LSBs.
- in_mode  in  3  0 NONE, 1 ETA, 2 T0, 3 T1, 4 GAMMA1; 5–7 treated as NONE.
- in_dir  in  1  0 uncenter, 1 center.
- in_sec_lvl  in  3  2, 3 or 5; any other value treated as 5.
- in_last  in  1  end-of-polynomial tag, passed through.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*W  converted coefficients.
- out_last  out  1  aligned in_last.
- out_err  out  LANES  per-lane range error for this beat.
- err_sticky  out  1  OR of all out_err since last clear.
- err_clr  in  1  clears err_sticky.

Behaviour:
- Constants per beat:
  - ETA = 4 if sec_lvl == 3, else 2.
  - GAMMA1 = 2^17 if sec_lvl == 2, else 2^19.
  - T = 4096.
- Uncenter (dir = 0), input v in [0, Q):
  - NONE: v.
  - ETA: v > ETA ? ETA + Q − v : ETA − v.
  - T1: t1 = (v + T − 1) >> D.
  - T0: t0 = v − (t1 << D) (signed, 24 bit); out = T − t0.
  - GAMMA1: v > GAMMA1 ? GAMMA1 + Q − v : GAMMA1 − v.
  - err when v ≥ Q.
- Center (dir = 1), input packed v:
  - ETA, T0, GAMMA1 (K = ETA, T or GAMMA1): v ≤ K ? K − v : Q + K − v.
  - T1: v << D.
  - NONE: v.
  - err conditions:
    - ETA: v > 2·ETA.
    - T0: v ≥ 2^D.
    - T1: v ≥ 2^10.
    - GAMMA1: v ≥ 2·GAMMA1.
    - NONE: v ≥ Q.
- Erroring lanes still output the formula result, truncated to W bits; no saturation.
- Pipeline and latency:
  - Two register stages, latency 2 cycles from accept to out_valid with no stall.
  - S1 registers data, mode, dir, sec_lvl, last, t1, and the comparisons.
  - S2 registers the selected subtraction result and err.
  - Sideband (mode, dir, sec_lvl) travels with each beat; consecutive beats may differ.
- Handshake:
  - in_ready = !(s1_valid & s2_valid & !out_ready).
  - Full throughput: one beat per cycle while out_ready = 1.
  - out_data, out_last and out_err hold stable while out_valid & !out_ready.
  - Bubbles collapse: S1 advances whenever S2 is empty or draining.
- Reset (rst = 0 at a clock edge):
  - s1_valid, s2_valid, out_valid and err_sticky go to 0.
  - out_data, out_err and out_last go to 0.
  - in_ready reads 1 in the first cycle after reset.
  - Reset mid-operation discards in-flight beats without emitting them.
- err_sticky:
  - Set in any cycle where out_valid & out_ready & |out_err.
  - err_clr has priority over a simultaneous set.

Decomposition:
- Shared package:
  - Q, mode encodings (M_NONE … M_GAMMA1), DIR_UNCENTER/DIR_CENTER.
  - Functions returning ETA and GAMMA1 from sec_lvl.
- Sub-module coeff_center_lane: one lane's S1 compare and S2 select datapath, instantiated LANES times.
- Handshake and valid logic stays in the top.

Test Plan:
- Uncenter, sec_lvl 3, ETA, lane values {0, 4, Q−1, Q−4} -> {4, 0, 5, 8}, err = 0, out_valid at cycle +2.
- Uncenter T1/T0, v = 5000 -> T1 = 1, T0 = 7288; v = Q−1 -> T1 = 1023. Center T0 of 7288 -> 8377225, i.e. −3192 mod Q.
- Center GAMMA1, sec_lvl 2: v = 0 -> 131072; v = 131073 -> Q−1; v = 262144 -> err lane set and err_sticky = 1. Then err_clr -> err_sticky = 0.
- Backpressure: stream 8 beats with out_ready low for cycles 3–6. Required: in_ready drops once both stages are full, no beat lost or duplicated, out_data stable while stalled, out_last on beat 8 only.
- Mixed sideband: back-to-back beats alternating dir/mode/sec_lvl each cycle. Each output matches its own sideband, throughput 1 beat/cycle.
- Reset mid-stream: assert rst = 0 with two beats in flight -> next cycle out_valid = 0, err_sticky = 0, in_ready = 1, no stale beat emitted afterwards.
